// File: rtl/core_ram.sv
// rtl/core_ram.sv - shared program/data memory for the accumulator core with a host load/readback port
// The host owns memory while core_hold is high; RELEASE hands it to the core until the host asks again.

module core_ram #(
   parameter  int word_width = 8,
   parameter  int depth      = word_width,
   localparam int aw         = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [aw-1:0]         pc_addr,
   output logic [word_width-1:0] pc_data,
   input  logic [aw-1:0]         op_addr,
   output logic [word_width-1:0] op_data,
   input  logic                  write,
   input  logic [word_width-1:0] wdata,
   output logic                  core_hold,
   input  logic                  host_valid,
   output logic                  host_ready,
   input  logic [1:0]            host_cmd,
   input  logic [word_width-1:0] host_data,
   output logic                  rdata_valid,
   output logic [word_width-1:0] rdata
);

   typedef enum logic {
      HOST = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] CMD_SETADDR = 2'b00;
   localparam logic [1:0] CMD_WRITE   = 2'b01;
   localparam logic [1:0] CMD_READ    = 2'b10;
   localparam logic [1:0] CMD_RELEASE = 2'b11;

   state_t                  state;
   state_t                  state_next;
   logic [aw-1:0]           ptr;
   logic [aw-1:0]           ptr_inc;
   logic                    accept;
   logic                    core_we;
   logic [word_width-1:0]   mem [depth];

   assign pc_data = mem[pc_addr];
   assign op_data = mem[op_addr];

   // Core writes follow the registered hold, so the write on the RUN->HOST edge still lands.
   assign core_we = write && !core_hold;
   assign ptr_inc = (ptr == aw'(depth - 1)) ? '0 : ptr + aw'(1);

   always_comb begin
      state_next = state;
      host_ready = 1'b0;
      accept     = 1'b0;
      case (state)
         HOST: begin
            host_ready = 1'b1;
            accept     = host_valid;
            if (host_valid && host_cmd == CMD_RELEASE) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (host_valid) begin
               state_next = HOST;
            end
         end
         default: state_next = HOST;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HOST;
         core_hold <= 1'b1;
      end else begin
         state     <= state_next;
         core_hold <= (state_next == HOST);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr         <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         if (accept) begin
            case (host_cmd)
               CMD_SETADDR: ptr <= host_data[aw-1:0];
               CMD_WRITE:   ptr <= ptr_inc;
               CMD_READ: begin
                  rdata       <= mem[ptr];
                  rdata_valid <= 1'b1;
                  ptr         <= ptr_inc;
               end
               default: ptr <= ptr;
            endcase
         end
      end
   end

   // Host and core writers are mutually exclusive because accept only exists in HOST.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else if (accept && host_cmd == CMD_WRITE) begin
         mem[ptr] <= host_data;
      end else if (core_we) begin
         mem[op_addr] <= wdata;
      end
   end

endmodule

// File: tb/tb_core_ram.sv
// tb/tb_core_ram.sv - directed and randomized checks of core_ram against a behavioural memory model

module tb_core_ram;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] pc_addr = '0;
   logic [7:0] pc_data;
   logic [2:0] op_addr = '0;
   logic [7:0] op_data;
   logic       write = 1'b0;
   logic [7:0] wdata = '0;
   logic       core_hold;
   logic       host_valid = 1'b0;
   logic       host_ready;
   logic [1:0] host_cmd = '0;
   logic [7:0] host_data = '0;
   logic       rdata_valid;
   logic [7:0] rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_mem [DEPTH];
   int         m_ptr;
   bit         m_hold;
   bit         m_valid;
   logic [7:0] m_rdata;
   logic [7:0] image [DEPTH];

   core_ram dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pc_addr     (pc_addr),
      .pc_data     (pc_data),
      .op_addr     (op_addr),
      .op_data     (op_data),
      .write       (write),
      .wdata       (wdata),
      .core_hold   (core_hold),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .host_cmd    (host_cmd),
      .host_data   (host_data),
      .rdata_valid (rdata_valid),
      .rdata       (rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_ptr   = 0;
      m_hold  = 1'b1;
      m_valid = 1'b0;
      m_rdata = 8'h00;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ":core_hold"}, 32'(core_hold), 32'(m_hold));
      chk({tag, ":host_ready"}, 32'(host_ready), 32'(m_hold));
      chk({tag, ":rdata_valid"}, 32'(rdata_valid), 32'(m_valid));
      chk({tag, ":rdata"}, 32'(rdata), 32'(m_rdata));
      chk({tag, ":pc_data"}, 32'(pc_data), 32'(m_mem[pc_addr]));
      chk({tag, ":op_data"}, 32'(op_data), 32'(m_mem[op_addr]));
   endtask

   // Apply the spec's per-edge rules to the model, then advance the DUT one clock and compare.
   task automatic cycle(input string tag);
      m_valid = 1'b0;
      if (m_hold) begin
         if (host_valid) begin
            case (host_cmd)
               2'd0: m_ptr = int'(host_data) % DEPTH;
               2'd1: begin
                  m_mem[m_ptr] = host_data;
                  m_ptr = (m_ptr + 1) % DEPTH;
               end
               2'd2: begin
                  m_rdata = m_mem[m_ptr];
                  m_valid = 1'b1;
                  m_ptr = (m_ptr + 1) % DEPTH;
               end
               default: m_hold = 1'b0;
            endcase
         end
      end else begin
         if (write) m_mem[op_addr] = wdata;
         if (host_valid) m_hold = 1'b1;
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic host(input logic [1:0] cmd, input logic [7:0] data);
      host_valid = 1'b1;
      host_cmd   = cmd;
      host_data  = data;
   endtask

   task automatic idle();
      host_valid = 1'b0;
      write      = 1'b0;
   endtask

   initial begin
      model_reset();

      // Reset state
      @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Load 11,22,33 from address 0
      host(2'd0, 8'h00); cycle("setaddr0");
      host(2'd1, 8'h11); cycle("wr11");
      host(2'd1, 8'h22); cycle("wr22");
      host(2'd1, 8'h33); cycle("wr33");
      idle();
      pc_addr = 3'd1;
      #1;
      chk("pc_data_at_1", 32'(pc_data), 32'h22);

      // Pointer wrap 7 -> 0
      host(2'd0, 8'h07); cycle("setaddr7");
      host(2'd1, 8'hAA); cycle("wrAA");
      host(2'd1, 8'hBB); cycle("wrBB");
      idle();
      pc_addr = 3'd7; op_addr = 3'd0;
      #1;
      chk("mem7_AA", 32'(pc_data), 32'hAA);
      chk("mem0_BB_wrap", 32'(op_data), 32'hBB);

      host(2'd2, 8'h00); cycle("read_ptr1");
      chk("read_ptr1_valid", 32'(rdata_valid), 32'h1);
      chk("read_ptr1_data", 32'(rdata), 32'h22);
      idle(); cycle("read_pulse_end");
      chk("rdata_valid_pulse", 32'(rdata_valid), 32'h0);
      chk("rdata_hold", 32'(rdata), 32'h22);

      // Release core and let it write mem[4]
      host(2'd0, 8'h04); cycle("setaddr4");
      chk("hold_before_release", 32'(core_hold), 32'h1);
      host(2'd3, 8'h00); cycle("release");
      chk("hold_after_release", 32'(core_hold), 32'h0);
      chk("ready_in_run", 32'(host_ready), 32'h0);
      idle();
      write = 1'b1; op_addr = 3'd4; wdata = 8'h5C;
      #1;
      chk("op_data_old", 32'(op_data), 32'h00);
      cycle("core_wr4");
      chk("op_data_new", 32'(op_data), 32'h5C);

      // Host request in RUN: first cycle refused, core write in it still lands
      write = 1'b1; op_addr = 3'd5; wdata = 8'h66;
      host(2'd2, 8'h00); cycle("run_req");
      chk("run_req_hold", 32'(core_hold), 32'h1);
      chk("run_req_not_accepted", 32'(rdata_valid), 32'h0);
      chk("core_wr_on_handover", 32'(op_data), 32'h66);
      op_addr = 3'd6; wdata = 8'h77;
      cycle("host_read_after_run");
      chk("held_write_ignored", 32'(op_data), 32'h00);
      chk("read_after_run_valid", 32'(rdata_valid), 32'h1);
      chk("read_after_run_data", 32'(rdata), 32'h5C);
      idle(); cycle("idle1");

      // Asynchronous reset while a READ is pending
      host(2'd2, 8'h00);
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_outputs("async_reset");
      for (int i = 0; i < DEPTH; i++) begin
         pc_addr = 3'(i);
         #1;
         chk("mem_cleared", 32'(pc_data), 32'h00);
      end
      @(posedge clk);
      #1;
      chk("no_valid_after_reset", 32'(rdata_valid), 32'h0);
      idle();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Load a random image, then 9 back-to-back READs from address 3
      host(2'd0, 8'h00); cycle("load_setaddr");
      for (int i = 0; i < DEPTH; i++) begin
         image[i] = 8'($urandom);
         host(2'd1, image[i]); cycle("load_wr");
      end
      host(2'd0, 8'h03); cycle("bb_setaddr");
      host(2'd2, 8'h00);
      for (int i = 0; i < 9; i++) begin
         cycle("bb_read");
         chk("bb_valid", 32'(rdata_valid), 32'h1);
         chk("bb_data", 32'(rdata), 32'(image[(3 + i) % DEPTH]));
      end
      idle(); cycle("bb_end");
      chk("bb_pulse_end", 32'(rdata_valid), 32'h0);

      // Randomized traffic in both ownership states
      for (int n = 0; n < 400; n++) begin
         host_valid = ($urandom_range(0, 3) == 0);
         host_cmd   = 2'($urandom);
         host_data  = 8'($urandom);
         write      = 1'($urandom);
         wdata      = 8'($urandom);
         op_addr    = 3'($urandom);
         pc_addr    = 3'($urandom);
         cycle("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/core_ram.md
Name: core_ram

Overview:
- Memory responder for the accumulator core's two read ports (program at PC_ADRR, operand at operand_addr) and its `write` strobe.
- Adds a host command port (valid/ready) with a single ownership state machine. The host loads or reads back memory while the core is held, then releases the core to run.

Parameters:
- word_width, 8, data width; must match the core.
- depth, word_width, number of words.
- aw, $clog2(depth), address width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- pc_addr  in  aw  core program fetch address
- pc_data  out  word_width  mem[pc_addr], combinational
- op_addr  in  aw  core operand address
- op_data  out  word_width  mem[op_addr], combinational
- write  in  1  core write strobe
- wdata  in  word_width  core write data, written to mem[op_addr]
- core_hold  out  1  registered; 1 = core must stall/hold reset, host owns memory
- host_valid  in  1  host command valid
- host_ready  out  1  command accepted when host_valid & host_ready
- host_cmd  in  2  00 SETADDR, 01 WRITE, 10 READ, 11 RELEASE
- host_data  in  word_width  SETADDR: address in [aw-1:0]; WRITE: data
- rdata_valid  out  1  one-cycle pulse
- rdata  out  word_width  read result

Behaviour:
- Reset (async, reset_n=0):
  - all mem words = 0; state = HOST; core_hold = 1; ptr = 0; rdata = 0; rdata_valid = 0.
  - The core starts held so a program is loaded first.
- States:
  - HOST: core_hold=1, host_ready=1.
  - RUN: core_hold=0, host_ready=0.
- HOST commands (each accepted in one cycle):
  - SETADDR: ptr <= host_data[aw-1:0].
  - WRITE: mem[ptr] <= host_data; ptr <= ptr+1.
  - READ: rdata <= mem[ptr]; rdata_valid=1 the next cycle only (1-cycle latency); ptr <= ptr+1.
  - RELEASE: state <= RUN; core_hold <= 0 next cycle; ptr unchanged.
- Pointer wraps depth-1 -> 0, modulo depth; no error.
- RUN:
  - core write honoured only while registered core_hold==0: mem[op_addr] <= wdata at the edge.
  - Any host_valid in RUN: state <= HOST, core_hold <= 1 next cycle. The command is NOT accepted (host_ready=0) and is accepted in the first HOST cycle if still valid.
  - host_ready is combinational from state only, never from host_valid.
- Core write in the same edge as the RUN->HOST transition is still honoured (core_hold was 0). Writes while core_hold=1 are ignored.
- Core write is ignored in HOST state.
- Reads are asynchronous and read-before-write: a core write to address X is visible on pc_data/op_data for X only after the clock edge.
- pc_data and op_data are valid in every state, including HOST.
- rdata holds its value until the next READ; rdata_valid is a pulse.
- Reset mid-operation: immediate return to reset values. In-flight READ result is lost (no rdata_valid). Memory contents are cleared.
- Out-of-range SETADDR (depth not a power of two): upper bits beyond aw are ignored; addresses >= depth alias modulo 2^aw. Use power-of-two depth only.

Test Plan:
- Reset, then SETADDR 0, WRITE 0x11, 0x22, 0x33 -> mem[0..2] = 11,22,33; ptr=3; pc_addr=1 gives pc_data=0x22.
- SETADDR 7, WRITE 0xAA, WRITE 0xBB (depth 8) -> mem[7]=AA, mem[0]=BB (wrap); READ at ptr 1 -> rdata_valid pulses 1 cycle after accept.
- RELEASE -> core_hold 1->0 one cycle later; host_ready=0. Core write=1, op_addr=4, wdata=0x5C -> mem[4]=0x5C; op_data shows old value in the write cycle and 0x5C after the edge.
- In RUN, raise host_valid with READ at ptr 4 -> not accepted in the first cycle; core_hold=1 next cycle. A core write in that first cycle lands, a core write in the next cycle is ignored. READ is accepted in HOST and returns 0x5C.
- Assert reset_n=0 asynchronously mid-READ (between accept and result) -> rdata_valid stays 0, all mem=0, core_hold=1, host_ready=1 immediately.
- Back-to-back READs over 9 addresses with host_valid held high -> 9 consecutive rdata_valid pulses, ptr wraps, data matches the loaded image.
